// File: rtl/uart_tx_frame_engine.sv
// uart_tx_frame_engine: UART transmitter serialising start, LSB-first data, optional parity and
// stop bits on an oversampled baud tick, with break override and abort on enable loss.
module uart_tx_frame_engine #(
   parameter int DATA_W_MAX = 8,
   parameter int OSR_A = 16,
   parameter int OSR_B = 13
) (
   input  logic                  clk_in,
   input  logic                  rst_in,
   input  logic                  enable_in,
   input  logic                  baud_tick_in,
   input  logic                  osm_sel_in,
   input  logic [3:0]            wls_in,
   input  logic                  pen_in,
   input  logic                  eps_in,
   input  logic                  sp_in,
   input  logic                  stb_in,
   input  logic                  break_in,
   input  logic [DATA_W_MAX-1:0] data_in,
   input  logic                  data_valid_in,
   output logic                  data_ready_out,
   output logic                  serial_out,
   output logic                  busy_out,
   output logic                  done_out
);
   localparam int OSR_M = OSR_A > OSR_B ? OSR_A : OSR_B;
   localparam int TW = $clog2(2 * OSR_M) + 1;
   localparam logic [TW-1:0] ONE = TW'(1);
   localparam logic [3:0] NMAX = 4'(DATA_W_MAX);
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
   state_t state;
   logic [TW-1:0] tick_cnt, osr_q, lim, stop_lim;
   logic [3:0] bit_cnt, n_q, n_c;
   logic [DATA_W_MAX-1:0] sh_q, masked;
   logic pen_q, stb_q, par_q, line_q, busy_q, done_q;
   assign n_c = wls_in < 4'd5 ? 4'd5 : (wls_in > NMAX ? NMAX : wls_in);
   assign masked = data_in & ~({DATA_W_MAX{1'b1}} << n_c);
   // a 5-bit character with the extra stop bit gets one and a half stop bits
   assign stop_lim = !stb_q ? osr_q - ONE :
                     (n_q == 4'd5 ? osr_q + (osr_q >> 1) - ONE : (osr_q << 1) - ONE);
   assign lim = state == STOP ? stop_lim : osr_q - ONE;
   assign data_ready_out = state == IDLE && enable_in && !rst_in;
   assign serial_out = line_q && !break_in;
   assign busy_out = busy_q;
   assign done_out = done_q;
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state <= IDLE;
         line_q <= 1'b1;
         busy_q <= 1'b0;
         done_q <= 1'b0;
         tick_cnt <= '0;
         bit_cnt <= '0;
      end else begin
         done_q <= 1'b0;
         if (state != IDLE && !enable_in) begin
            state <= IDLE;
            line_q <= 1'b1;
            busy_q <= 1'b0;
            tick_cnt <= '0;
            bit_cnt <= '0;
         end else if (state == IDLE) begin
            if (data_valid_in && data_ready_out) begin
               state <= START;
               line_q <= 1'b0;
               busy_q <= 1'b1;
               tick_cnt <= '0;
               bit_cnt <= '0;
               sh_q <= masked;
               n_q <= n_c;
               pen_q <= pen_in;
               stb_q <= stb_in;
               par_q <= sp_in ? !eps_in : (eps_in ? ^masked : ~^masked);
               osr_q <= osm_sel_in ? TW'(OSR_B) : TW'(OSR_A);
            end
         end else if (baud_tick_in) begin
            if (tick_cnt != lim) tick_cnt <= tick_cnt + ONE;
            else begin
               tick_cnt <= '0;
               case (state)
                  START: begin
                     state <= DATA;
                     line_q <= sh_q[0];
                  end
                  DATA: begin
                     if (bit_cnt == n_q - 4'd1) begin
                        state <= pen_q ? PARITY : STOP;
                        line_q <= pen_q ? par_q : 1'b1;
                     end else begin
                        bit_cnt <= bit_cnt + 4'd1;
                        sh_q <= sh_q >> 1;
                        line_q <= sh_q[1];
                     end
                  end
                  PARITY: begin
                     state <= STOP;
                     line_q <= 1'b1;
                  end
                  default: begin
                     state <= IDLE;
                     busy_q <= 1'b0;
                     done_q <= 1'b1;
                  end
               endcase
            end
         end
      end
   end
endmodule

// File: tb/tb_uart_tx_frame_engine.sv
// tb_uart_tx_frame_engine: directed literal frames plus a randomized run compared every cycle
// against a tick-count/segment-list model of the transmitted frame.
module tb_uart_tx_frame_engine;
   localparam int DW = 8, OA = 16, OB = 13;
   logic clk = 1'b0;
   logic rst, en, tick, osm, pen, eps, sp, stb, brk, valid;
   logic [3:0] wls;
   logic [DW-1:0] data;
   logic ready, ser, busy, done;
   int n_checks = 0, n_fail = 0;
   bit tick_all = 1'b1;
   bit m_valid = 1'b0, m_active = 1'b0, m_done = 1'b0;
   int m_t, m_total, nseg, acc_cnt = 0, osr_m, n_m, ones_m;
   int seg_val[12], seg_dur[12];
   logic cap[0:2047];
   int cap_len, busy_cnt;

   uart_tx_frame_engine #(.DATA_W_MAX(DW), .OSR_A(OA), .OSR_B(OB)) dut (
      .clk_in(clk), .rst_in(rst), .enable_in(en), .baud_tick_in(tick), .osm_sel_in(osm),
      .wls_in(wls), .pen_in(pen), .eps_in(eps), .sp_in(sp), .stb_in(stb), .break_in(brk),
      .data_in(data), .data_valid_in(valid), .data_ready_out(ready), .serial_out(ser),
      .busy_out(busy), .done_out(done));

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
      end
   endtask

   function automatic int line_at(input int t);
      int p = t;
      for (int i = 0; i < nseg; i++) begin
         if (p < seg_dur[i]) return seg_val[i];
         p -= seg_dur[i];
      end
      return 1;
   endfunction

   // frame model: a list of (level, duration-in-ticks) segments and a tick count since acceptance
   always @(posedge clk) begin
      if (rst) begin
         m_valid = 1'b1;
         m_active = 1'b0;
         m_done = 1'b0;
      end else begin
         m_done = 1'b0;
         if (m_active) begin
            if (!en) m_active = 1'b0;
            else if (tick) begin
               m_t++;
               if (m_t == m_total) begin
                  m_active = 1'b0;
                  m_done = 1'b1;
               end
            end
         end else if (en && valid) begin
            osr_m = osm ? OB : OA;
            n_m = wls < 5 ? 5 : (wls > DW ? DW : int'(wls));
            ones_m = 0;
            seg_val[0] = 0;
            seg_dur[0] = osr_m;
            nseg = 1;
            for (int i = 0; i < n_m; i++) begin
               seg_val[nseg] = (int'(data) >> i) & 1;
               ones_m += seg_val[nseg];
               seg_dur[nseg] = osr_m;
               nseg++;
            end
            if (pen) begin
               seg_val[nseg] = sp ? int'(!eps) : (eps ? ones_m % 2 : 1 - ones_m % 2);
               seg_dur[nseg] = osr_m;
               nseg++;
            end
            seg_val[nseg] = 1;
            seg_dur[nseg] = !stb ? osr_m : (n_m == 5 ? osr_m + osr_m / 2 : 2 * osr_m);
            nseg++;
            m_total = 0;
            for (int i = 0; i < nseg; i++) m_total += seg_dur[i];
            m_t = 0;
            m_active = 1'b1;
            acc_cnt++;
         end
      end
   end

   initial forever begin
      @(negedge clk);
      if (m_valid) begin
         chk("serial_out", ser, brk ? 0 : (m_active ? line_at(m_t) : 1));
         chk("busy_out", busy, m_active);
         chk("done_out", done, m_done);
         chk("data_ready_out", ready, !m_active && en && !rst);
      end
   end

   initial begin
      tick = 1'b0;
      forever begin
         @(posedge clk);
         #1 tick = tick_all ? 1'b1 : ($urandom_range(0, 3) == 0);
      end
   end

   task automatic start_frame(input logic [7:0] d, input logic [3:0] w, input logic p, e, s,
                              input logic st, input logic o, input bit keep);
      int a0;
      #1;
      data = d; wls = w; pen = p; eps = e; sp = s; stb = st; osm = o; valid = 1'b1;
      a0 = acc_cnt;
      for (int i = 0; i < 3000; i++) begin
         @(posedge clk);
         #1;
         if (acc_cnt != a0) break;
      end
      if (acc_cnt == a0) begin
         n_checks++;
         n_fail++;
         $display("FAIL accept_timeout at %0t: no acceptance within 3000 cycles", $time);
      end
      if (!keep) valid = 1'b0;
   endtask

   task automatic capture(input int brk_on, input int brk_off, input int abort_at);
      cap_len = 0;
      busy_cnt = 0;
      for (int c = 1; c < 2000; c++) begin
         @(negedge clk);
         cap[c] = ser;
         if (busy) busy_cnt++;
         if (done) begin
            cap_len = c;
            return;
         end
         if (c == abort_at) begin
            #1 en = 1'b0;
            return;
         end
         if (c == brk_on) #1 brk = 1'b1;
         if (c == brk_off) #1 brk = 1'b0;
      end
      n_checks++;
      n_fail++;
      $display("FAIL frame_timeout at %0t: no done_out within 2000 cycles", $time);
   endtask

   initial begin
      logic [9:0] e1;
      logic [6:0] e2;
      int lows, dseen;
      rst = 1'b1; en = 1'b1; osm = 1'b0; pen = 1'b0; eps = 1'b0; sp = 1'b0; stb = 1'b0;
      brk = 1'b0; valid = 1'b0; wls = 4'd8; data = '0;
      repeat (3) @(negedge clk);
      chk("reset_ready", ready, 0);
      chk("reset_serial", ser, 1);
      chk("reset_busy", busy, 0);
      chk("reset_done", done, 0);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("idle_ready", ready, 1);

      start_frame(8'h55, 4'd8, 0, 0, 0, 0, 0, 0);
      capture(0, 0, 0);
      e1 = 10'b1010101010;
      chk("f55_done_clock", cap_len - 1, 160);
      chk("f55_busy_clocks", busy_cnt, 160);
      for (int k = 0; k < 10; k++) chk($sformatf("f55_bit%0d", k), cap[k * 16 + 8], e1[k]);

      start_frame(8'h13, 4'd5, 1, 1, 0, 1, 1, 0);
      capture(0, 0, 0);
      e2 = 7'b1100110;
      for (int k = 0; k < 7; k++) chk($sformatf("f13_bit%0d", k), cap[k * 13 + 7], e2[k]);
      chk("f13_stop_mid", cap[100], 1);
      chk("f13_stop_end", cap[110], 1);
      chk("f13_done_clock", cap_len - 1, 110);

      start_frame(8'h07, 4'd7, 1, 0, 1, 0, 0, 0);
      capture(0, 0, 0);
      chk("f07_d2", cap[56], 1);
      chk("f07_d3", cap[72], 0);
      chk("f07_stick_eps0", cap[136], 1);
      chk("f07_done_clock", cap_len - 1, 160);
      start_frame(8'h07, 4'd7, 1, 1, 1, 0, 0, 0);
      capture(0, 0, 0);
      chk("f07_stick_eps1", cap[136], 0);

      start_frame(8'hA0, 4'd8, 0, 0, 0, 0, 0, 1);
      data = 8'h0F;
      capture(0, 0, 0);
      chk("b2b_first_done", cap_len - 1, 160);
      @(negedge clk);
      chk("b2b_start_line", ser, 0);
      chk("b2b_start_busy", busy, 1);
      #1 valid = 1'b0;
      capture(0, 0, 0);
      chk("b2b_second_d0", cap[23], 1);
      chk("b2b_second_d4", cap[87], 0);
      chk("b2b_second_len", cap_len, 160);

      start_frame(8'hC3, 4'd8, 0, 0, 0, 0, 0, 0);
      capture(0, 0, 70);
      @(negedge clk);
      chk("abort_serial", ser, 1);
      chk("abort_busy", busy, 0);
      chk("abort_done", done, 0);
      chk("abort_ready_disabled", ready, 0);
      dseen = 0;
      repeat (40) begin
         @(negedge clk);
         if (done) dseen++;
      end
      chk("abort_no_done", dseen, 0);
      #1 en = 1'b1;
      start_frame(8'h5A, 4'd8, 0, 0, 0, 0, 0, 0);
      capture(0, 0, 0);
      chk("reenable_d0", cap[24], 0);
      chk("reenable_d1", cap[40], 1);
      chk("reenable_done_clock", cap_len - 1, 160);

      start_frame(8'hFF, 4'd12, 0, 0, 0, 0, 0, 0);
      capture(55, 150, 0);
      lows = 0;
      for (int c = 56; c <= 150; c++) if (cap[c] !== 1'b0) lows++;
      chk("break_not_low_cycles", lows, 0);
      chk("break_pre_d1", cap[40], 1);
      chk("break_release", cap[151], 1);
      chk("wls_clamp_done_clock", cap_len - 1, 160);

      tick_all = 1'b0;
      for (int i = 0; i < 20000; i++) begin
         @(negedge clk);
         #1;
         rst = ($urandom_range(0, 4999) == 0);
         if ($urandom_range(0, 1999) == 0) en = 1'b0;
         else if (!en && $urandom_range(0, 9) == 0) en = 1'b1;
         if ($urandom_range(0, 299) == 0) brk = !brk;
         valid = $urandom_range(0, 3) != 0;
         data = DW'($urandom);
         wls = 4'($urandom);
         osm = 1'($urandom);
         pen = 1'($urandom);
         eps = 1'($urandom);
         sp = 1'($urandom);
         stb = 1'($urandom);
      end
      @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/uart_tx_frame_engine.md
Name: uart_tx_frame_engine

Overview:
- Parametrised UART transmit engine; successor to the fixed 5–8-bit TX shifter.
- Accepts one character per valid/ready handshake and serialises start, data (LSB first), optional parity and stop bits.
- Bit timing comes from a baud tick enable with selectable oversampling; one clock domain.
- Sits between the THR/TX FIFO and the serial pin; adds stick parity, break, abort and frame-done reporting.

Parameters:
- DATA_W_MAX, 8, widest character supported; legal range 5..9.
- OSR_A, 16, baud ticks per bit when osm_sel_in=0.
- OSR_B, 13, baud ticks per bit when osm_sel_in=1.

Ports:
- clk_in  input  1  system clock; all logic on rising edge.
- rst_in  input  1  synchronous reset, active high.
- enable_in  input  1  transmitter enable; low aborts the frame.
- baud_tick_in  input  1  one-cycle baud enable (16x/13x rate).
- osm_sel_in  input  1  oversampling select: 0=OSR_A, 1=OSR_B.
- wls_in  input  4  data bits per character (5..DATA_W_MAX).
- pen_in  input  1  parity enable.
- eps_in  input  1  even parity select.
- sp_in  input  1  stick parity.
- stb_in  input  1  extra stop bit select.
- break_in  input  1  force line low.
- data_in  input  DATA_W_MAX  character to send.
- data_valid_in  input  1  character valid.
- data_ready_out  output  1  engine can accept a character.
- serial_out  output  1  TX line.
- busy_out  output  1  frame in progress.
- done_out  output  1  one-cycle pulse at end of last stop bit.

Behaviour:
- Reset (rst_in=1 at an edge): state IDLE, serial_out=1, data_ready_out=0 during reset, busy_out=0, done_out=0, all counters 0.
- data_ready_out is combinational: (state==IDLE) && enable_in && !rst_in.
- Acceptance occurs at the edge where data_valid_in && data_ready_out.
- At acceptance the engine latches data_in, wls_in, pen_in, eps_in, sp_in, stb_in and osm_sel_in. Later changes to these inputs do not affect the frame in flight.
- wls_in clamping: values <5 are treated as 5; values >DATA_W_MAX are treated as DATA_W_MAX. Unused upper data bits are ignored.
- Let OSR be the latched oversampling value. A bit period is OSR baud_tick_in pulses, counted by tick_cnt.
- The current bit ends on the cycle where baud_tick_in=1 and tick_cnt==OSR-1; tick_cnt then resets to 0.
- Ticks that arrive while in IDLE are ignored.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE -> START on acceptance. serial_out=0 from the cycle after acceptance; latency is 1 clock. busy_out=1 from the same cycle.
  - START (line 0, 1 bit) -> DATA.
  - DATA: bit_cnt runs from 0 to N-1 and serial_out=data[bit_cnt]. After bit N-1, go to PARITY if pen else STOP.
  - PARITY: line = sp ? !eps : (eps ? ^data[N-1:0] : ~^data[N-1:0]), computed over the latched N bits only. Then -> STOP.
  - STOP: line 1. Duration is 1 bit if !stb. If stb and N==5, duration is OSR + OSR/2 ticks (integer division; 24 for 16, 19 for 13). If stb and N>5, duration is 2 bits.
  - End of STOP -> IDLE. done_out pulses for that one cycle, busy_out=0 and data_ready_out may be 1 in the next cycle.
- Back-to-back: a character accepted the cycle after done_out produces a START with no idle gap beyond 1 clock.
- Abort: enable_in=0 in any non-IDLE state -> IDLE on the next edge. serial_out=1, busy_out=0, no done_out pulse, latched character discarded.
- break_in=1 forces serial_out=0 combinationally over the FSM output. FSM timing and handshake are unaffected. Release restores the FSM value on the same cycle.
- Reset mid-frame overrides everything: IDLE, line 1, no done_out pulse.
- Simultaneous abort and acceptance cannot occur, because ready requires enable_in.

Test Plan:
- Reset with osm_sel=0 and tick every cycle; send 0x55 with wls=8, no parity, 1 stop -> serial_out = 0,1,0,1,0,1,0,1,0,1 (start, data, stop), 16 clocks each; done_out at clock 160 after acceptance; busy_out high for 160 clocks.
- Send 0x13 with wls=5, pen=1, eps=1, stb=1, osm_sel=1 -> data bits 1,1,0,0,1; parity 1; stop high for 19 ticks; frame length 13*7+19=110 ticks.
- Send 0x07 with wls=7, pen=1, sp=1, eps=0 -> parity bit 1 regardless of data; repeat with eps=1 -> parity bit 0.
- Two characters 0xA0, 0x0F with data_valid_in held high -> second start bit begins 1 clock after first done_out; no extra idle.
- Deassert enable_in midway through data bit 3 -> next cycle serial_out=1, busy_out=0, no done_out pulse; after re-enable a new frame transmits correctly.
- Assert break_in during bit 2 of 0xFF, release during the stop bit -> line low throughout the break; done_out still occurs at nominal time; wls_in=12 with DATA_W_MAX=8 sends exactly 8 data bits.
